key_irq_controller: RTL and testbench

- Sequences the raw key inputs from the frontend into a debounced key register and per-key press interrupt requests for the system interrupt controller.
- Pipeline: 2-flop synchroniser, per-key debounce counter clocked by clk_ce, press-edge latch, acknowledge handshake.
- Serves the active-low key register at bus address 0x2052.
- Sits between the frontend joystick mapping and the CPU bus / interrupt controller.

---
 rtl/key_irq_controller.sv | 83 ++++++++
 tb/tb_key_irq_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_irq_controller.sv
// Key input conditioning: 2-flop synchroniser, per-key clock-enabled debounce,
// press-edge interrupt latch with acknowledge, and the active-low key register read port.
module key_irq_controller #(
    parameter int NUM_KEYS       = 8,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 4
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                clk_ce,
    input  logic [NUM_KEYS-1:0] keys_active,
    input  logic [23:0]         bus_address_in,
    input  logic [NUM_KEYS-1:0] irq_ack,
    output logic [7:0]          bus_data_out,
    output logic [NUM_KEYS-1:0] irq_req,
    output logic [NUM_KEYS-1:0] keys_stable
);

    localparam logic [23:0]      KEY_REG_ADDR = 24'h002052;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [NUM_KEYS-1:0] sync_q1;
    logic [NUM_KEYS-1:0] sync_q2;
    logic [NUM_KEYS-1:0] stable_q;
    logic [NUM_KEYS-1:0] stable_d;
    logic [NUM_KEYS-1:0] pending_q;
    logic [NUM_KEYS-1:0] press;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [7:0]          reg_val;

    // A changed level must be seen on DEBOUNCE_TICKS consecutive enabled ticks.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (clk_ce) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync_q2[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_q2[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable_d & ~stable_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            stable_q  <= '0;
            pending_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep the two sync stages a true 2-flop chain.
            sync_q1   <= keys_active;
            sync_q2   <= sync_q1;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            // A press on the same edge as its ack wins, so no event is lost.
            pending_q <= (pending_q & ~irq_ack) | press;
        end
    end

    assign irq_req     = pending_q;
    assign keys_stable = stable_q;

    // Register is active-low; unused upper bits read as 1.
    always_comb begin
        reg_val                 = '1;
        reg_val[NUM_KEYS-1:0]   = ~stable_q;
        bus_data_out            = (bus_address_in == KEY_REG_ADDR) ? reg_val : 8'h00;
    end

endmodule

// File: tb/tb_key_irq_controller.sv
// Randomised and directed stimulus for key_irq_controller, checked by a scoreboard
// fed from a sliding-window behavioural model of the debounce and interrupt rules.
module tb_key_irq_controller;

    localparam int NK = 8;
    localparam int D  = 4;
    localparam logic [15:0] WIN_MASK = 16'((1 << D) - 1);

    logic          clk_sys;
    logic          reset_n;
    logic          clk_ce;
    logic [NK-1:0] keys_active;
    logic [23:0]   bus_address_in;
    logic [NK-1:0] irq_ack;
    logic [7:0]    bus_data_out;
    logic [NK-1:0] irq_req;
    logic [NK-1:0] keys_stable;

    key_irq_controller #(
        .NUM_KEYS(NK),
        .DEBOUNCE_TICKS(D),
        .CNT_W(4)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .clk_ce(clk_ce),
        .keys_active(keys_active),
        .bus_address_in(bus_address_in),
        .irq_ack(irq_ack),
        .bus_data_out(bus_data_out),
        .irq_req(irq_req),
        .keys_stable(keys_stable)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    typedef struct packed {
        logic [NK-1:0] stable;
        logic [NK-1:0] irq;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: raw samples delayed two edges, then per-key window of enabled-tick samples.
    logic [NK-1:0] dly[$];
    logic [15:0]   win_bits [NK];
    int            win_cnt  [NK];
    logic [NK-1:0] m_stable;
    logic [NK-1:0] m_pend;

    always @(posedge clk_sys) begin
        logic [NK-1:0] s;
        logic [NK-1:0] pr;
        if (!reset_n) begin
            dly.delete();
            dly.push_back('0);
            dly.push_back('0);
            for (int i = 0; i < NK; i++) begin
                win_bits[i] = '0;
                win_cnt[i]  = 0;
            end
            m_stable = '0;
            m_pend   = '0;
        end else begin
            s = dly.pop_front();
            dly.push_back(keys_active);
            pr = '0;
            if (clk_ce) begin
                for (int i = 0; i < NK; i++) begin
                    win_bits[i] = {win_bits[i][14:0], s[i]};
                    if (win_cnt[i] < 16) win_cnt[i]++;
                    // Accept when the last D enabled samples all disagree with the current level.
                    if (win_cnt[i] >= D &&
                        (win_bits[i] & WIN_MASK) == (m_stable[i] ? 16'h0000 : WIN_MASK)) begin
                        if (!m_stable[i]) pr[i] = 1'b1;
                        m_stable[i] = ~m_stable[i];
                    end
                end
            end
            m_pend = (m_pend & ~irq_ack) | pr;
        end
        sb.push_back('{stable: m_stable, irq: m_pend});
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        exp_t e;
        logic [7:0] exp_bus;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_bus = (bus_address_in == 24'h002052) ? ~e.stable : 8'h00;
            check("keys_stable", keys_stable, e.stable);
            check("irq_req", irq_req, e.irq);
            check("bus_data_out", bus_data_out, exp_bus);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic ack_pulse(input logic [NK-1:0] m);
        irq_ack = m;
        tick(1);
        irq_ack = '0;
    endtask

    initial begin
        reset_n        = 1'b0;
        clk_ce         = 1'b1;
        keys_active    = 8'hFF;
        bus_address_in = 24'h002052;
        irq_ack        = '0;
        tick(5);
        reset_n = 1'b1;
        tick(10);

        // Everything released, then clear the presses the power-on level produced.
        keys_active = '0;
        tick(10);
        ack_pulse(8'hFF);
        tick(2);

        // Single press on key 0, ack, release.
        keys_active = 8'h01;
        tick(10);
        ack_pulse(8'h01);
        keys_active = 8'h00;
        tick(10);

        // Glitch rejection on key 3: 3 cycles rejected, 4 cycles accepted.
        keys_active = 8'h08;
        tick(3);
        keys_active = 8'h00;
        tick(10);
        keys_active = 8'h08;
        tick(4);
        keys_active = 8'h00;
        tick(12);
        ack_pulse(8'h08);
        tick(2);

        // clk_ce one cycle in four with key 5 pressed.
        keys_active = 8'h20;
        for (int c = 0; c < 40; c++) begin
            clk_ce = (c % 4 == 0);
            tick(1);
        end
        clk_ce = 1'b1;
        ack_pulse(8'h20);
        keys_active = 8'h00;
        tick(10);

        // Key 2 pending, released, re-pressed with ack landing on the re-rise edge.
        keys_active = 8'h04;
        tick(10);
        keys_active = 8'h00;
        tick(10);
        keys_active = 8'h04;
        tick(5);
        ack_pulse(8'h04);
        tick(5);
        ack_pulse(8'h04);
        keys_active = 8'h00;
        tick(10);

        // Address decode with 0x81 debounced.
        keys_active = 8'h81;
        tick(10);
        bus_address_in = 24'h002051;
        tick(1);
        bus_address_in = 24'h002053;
        tick(1);
        bus_address_in = 24'h102052;
        tick(1);
        bus_address_in = 24'h002052;
        tick(1);
        ack_pulse(8'h81);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) keys_active = NK'($urandom);
            clk_ce  = ($urandom_range(0, 2) != 0);
            irq_ack = NK'($urandom & $urandom & $urandom);
            case ($urandom_range(0, 4))
                0, 1:    bus_address_in = 24'h002052;
                2:       bus_address_in = 24'h002051;
                3:       bus_address_in = 24'h102052;
                default: bus_address_in = 24'($urandom);
            endcase
            tick(1);
        end
        irq_ack = '0;
        tick(3);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk_sys);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
